// File: rtl/mano_control_unit_if.sv
// -----------------------------------------------------------------------------
// mano_control_unit_if
// Bundle of signals between the Mano basic-computer control unit and its
// datapath.
//   Datapath -> control : IR, AC, DR, E
//   Control -> datapath : BUS_SEL, ALU_SEL, every register/memory strobe,
//                         plus SC, halted and instr_done for observation.
// Handshake: there is none. Every strobe is a level that the datapath acts on
// at the next rising clock edge. The datapath keeps IR/AC/DR/E stable through
// each T-state.
// Modports: master = control unit side, slave = datapath side.
// -----------------------------------------------------------------------------
interface mano_control_unit_if #(
   parameter int SC_W = 4
);
   logic [15:0]     IR;
   logic [15:0]     AC;
   logic [15:0]     DR;
   logic            E;
   logic [2:0]      BUS_SEL;
   logic [2:0]      ALU_SEL;
   logic            MEM_write;
   logic            AR_write, AR_increment, AR_clear;
   logic            PC_write, PC_increment, PC_clear;
   logic            DR_write, DR_increment, DR_clear;
   logic            AC_write, AC_increment, AC_clear;
   logic            IR_write;
   logic            TR_write, TR_increment, TR_clear;
   logic            OUTR_write;
   logic            E_write, E_clear, E_complement;
   logic [SC_W-1:0] SC;
   logic            halted;
   logic            instr_done;

   modport master (
      input  IR, AC, DR, E,
      output BUS_SEL, ALU_SEL, MEM_write,
             AR_write, AR_increment, AR_clear,
             PC_write, PC_increment, PC_clear,
             DR_write, DR_increment, DR_clear,
             AC_write, AC_increment, AC_clear,
             IR_write, TR_write, TR_increment, TR_clear, OUTR_write,
             E_write, E_clear, E_complement,
             SC, halted, instr_done
   );

   modport slave (
      output IR, AC, DR, E,
      input  BUS_SEL, ALU_SEL, MEM_write,
             AR_write, AR_increment, AR_clear,
             PC_write, PC_increment, PC_clear,
             DR_write, DR_increment, DR_clear,
             AC_write, AC_increment, AC_clear,
             IR_write, TR_write, TR_increment, TR_clear, OUTR_write,
             E_write, E_clear, E_complement,
             SC, halted, instr_done
   );
endinterface

// File: rtl/mano_control_unit.sv
// -----------------------------------------------------------------------------
// mano_control_unit
// Hardwired control unit for the Mano basic computer. It holds the sequence
// counter SC (T0..T6), the indirect flag I and the halt flag S. All
// datapath controls are decoded combinationally from SC, I, IR, AC, DR, E
// and S.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   ctl     : mano_control_unit_if.master. IR/AC/DR/E come in. Bus select,
//             ALU select, strobes, SC, halted and instr_done go out.
// SC and halted are the complete sequencing state. They are exported on the
// interface for observation.
// -----------------------------------------------------------------------------
module mano_control_unit #(
   parameter int SC_W = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   mano_control_unit_if.master ctl
);

   localparam logic [SC_W-1:0] T0 = SC_W'(0);
   localparam logic [SC_W-1:0] T1 = SC_W'(1);
   localparam logic [SC_W-1:0] T2 = SC_W'(2);
   localparam logic [SC_W-1:0] T3 = SC_W'(3);
   localparam logic [SC_W-1:0] T4 = SC_W'(4);
   localparam logic [SC_W-1:0] T5 = SC_W'(5);
   localparam logic [SC_W-1:0] T6 = SC_W'(6);

   typedef enum logic [2:0] {
      OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
      OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_REG = 3'd7
   } opcode_t;

   localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2,
                          BUS_DR = 3'd3, BUS_AC = 3'd4, BUS_IR = 3'd5,
                          BUS_MEM = 3'd7;
   localparam logic [2:0] ALU_AND = 3'b000, ALU_ADD = 3'b001, ALU_DR = 3'b010,
                          ALU_CMA = 3'b011, ALU_CIR = 3'b100, ALU_CIL = 3'b101;

   logic [SC_W-1:0] r_sc;
   logic            r_i;
   logic            r_halted;

   opcode_t    w_d;
   logic [2:0] w_bus_sel, w_alu_sel;
   logic       w_mem_w, w_ar_w, w_ar_inc, w_pc_w, w_pc_inc;
   logic       w_dr_w, w_dr_inc, w_ac_w, w_ac_inc, w_ac_clr;
   logic       w_ir_w, w_e_w, w_e_clr, w_e_cmp, w_done, w_hlt;

   assign w_d = opcode_t'(ctl.IR[14:12]);

   always_comb begin
      w_bus_sel = BUS_NONE;
      w_alu_sel = ALU_AND;
      w_mem_w   = 1'b0;
      w_ar_w    = 1'b0;
      w_ar_inc  = 1'b0;
      w_pc_w    = 1'b0;
      w_pc_inc  = 1'b0;
      w_dr_w    = 1'b0;
      w_dr_inc  = 1'b0;
      w_ac_w    = 1'b0;
      w_ac_inc  = 1'b0;
      w_ac_clr  = 1'b0;
      w_ir_w    = 1'b0;
      w_e_w     = 1'b0;
      w_e_clr   = 1'b0;
      w_e_cmp   = 1'b0;
      w_done    = 1'b0;
      w_hlt     = 1'b0;
      // Reset and the halt flag both silence every control.
      if (reset_n && !r_halted) begin
         case (r_sc)
            T0: begin w_bus_sel = BUS_PC;  w_ar_w = 1'b1; end
            T1: begin w_bus_sel = BUS_MEM; w_ir_w = 1'b1; w_pc_inc = 1'b1; end
            T2: begin w_bus_sel = BUS_IR;  w_ar_w = 1'b1; end
            T3: begin
               if (w_d == OP_REG) begin
                  w_done = 1'b1;
                  // I=1 here is an I/O opcode and finishes as a NOP.
                  // Only the highest set bit of IR[11:0] executes.
                  if (!r_i) begin
                     casez (ctl.IR[11:0])
                        12'b1???_????_????: w_ac_clr = 1'b1;
                        12'b01??_????_????: w_e_clr  = 1'b1;
                        12'b001?_????_????: begin w_alu_sel = ALU_CMA; w_ac_w = 1'b1; end
                        12'b0001_????_????: w_e_cmp  = 1'b1;
                        12'b0000_1???_????: begin w_alu_sel = ALU_CIR; w_ac_w = 1'b1; w_e_w = 1'b1; end
                        12'b0000_01??_????: begin w_alu_sel = ALU_CIL; w_ac_w = 1'b1; w_e_w = 1'b1; end
                        12'b0000_001?_????: w_ac_inc = 1'b1;
                        12'b0000_0001_????: w_pc_inc = ~ctl.AC[15];
                        12'b0000_0000_1???: w_pc_inc = ctl.AC[15];
                        12'b0000_0000_01??: w_pc_inc = (ctl.AC == 16'h0000);
                        12'b0000_0000_001?: w_pc_inc = ~ctl.E;
                        12'b0000_0000_0001: w_hlt    = 1'b1;
                        default: ;
                     endcase
                  end
               end else if (r_i) begin
                  w_bus_sel = BUS_MEM;
                  w_ar_w    = 1'b1;
               end
            end
            T4: begin
               case (w_d)
                  OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin w_bus_sel = BUS_MEM; w_dr_w = 1'b1; end
                  OP_STA: begin w_bus_sel = BUS_AC; w_mem_w = 1'b1; w_done = 1'b1; end
                  OP_BUN: begin w_bus_sel = BUS_AR; w_pc_w  = 1'b1; w_done = 1'b1; end
                  OP_BSA: begin w_bus_sel = BUS_PC; w_mem_w = 1'b1; w_ar_inc = 1'b1; end
                  default: ;
               endcase
            end
            T5: begin
               case (w_d)
                  OP_AND: begin w_alu_sel = ALU_AND; w_ac_w = 1'b1; w_done = 1'b1; end
                  OP_ADD: begin w_alu_sel = ALU_ADD; w_ac_w = 1'b1; w_e_w = 1'b1; w_done = 1'b1; end
                  OP_LDA: begin w_alu_sel = ALU_DR;  w_ac_w = 1'b1; w_done = 1'b1; end
                  OP_BSA: begin w_bus_sel = BUS_AR;  w_pc_w = 1'b1; w_done = 1'b1; end
                  OP_ISZ: w_dr_inc = 1'b1;
                  default: ;
               endcase
            end
            T6: begin
               // DR already holds the incremented word. Skip when it wrapped to zero.
               if (w_d == OP_ISZ) begin
                  w_bus_sel = BUS_DR;
                  w_mem_w   = 1'b1;
                  w_pc_inc  = (ctl.DR == 16'h0000);
                  w_done    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sc     <= T0;
         r_i      <= 1'b0;
         r_halted <= 1'b0;
      end else if (!r_halted) begin
         r_sc <= w_done ? T0 : r_sc + SC_W'(1);
         if (r_sc == T2) r_i <= ctl.IR[15];
         if (w_hlt) r_halted <= 1'b1;
      end
   end

   assign ctl.BUS_SEL      = w_bus_sel;
   assign ctl.ALU_SEL      = w_alu_sel;
   assign ctl.MEM_write    = w_mem_w;
   assign ctl.AR_write     = w_ar_w;
   assign ctl.AR_increment = w_ar_inc;
   assign ctl.AR_clear     = 1'b0;
   assign ctl.PC_write     = w_pc_w;
   assign ctl.PC_increment = w_pc_inc;
   assign ctl.PC_clear     = 1'b0;
   assign ctl.DR_write     = w_dr_w;
   assign ctl.DR_increment = w_dr_inc;
   assign ctl.DR_clear     = 1'b0;
   assign ctl.AC_write     = w_ac_w;
   assign ctl.AC_increment = w_ac_inc;
   assign ctl.AC_clear     = w_ac_clr;
   assign ctl.IR_write     = w_ir_w;
   assign ctl.TR_write     = 1'b0;
   assign ctl.TR_increment = 1'b0;
   assign ctl.TR_clear     = 1'b0;
   assign ctl.OUTR_write   = 1'b0;
   assign ctl.E_write      = w_e_w;
   assign ctl.E_clear      = w_e_clr;
   assign ctl.E_complement = w_e_cmp;
   assign ctl.SC           = r_sc;
   assign ctl.halted       = r_halted;
   assign ctl.instr_done   = w_done;

endmodule

// File: tb/tb_mano_control_unit.sv
module tb_mano_control_unit;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic [27:0] exp_q[$];

   always #5 clk = ~clk;

   mano_control_unit_if #(.SC_W(4)) ifc();
   mano_control_unit #(.SC_W(4)) dut (.clk(clk), .reset_n(reset_n), .ctl(ifc));

   // Observed word: {BUS_SEL, ALU_SEL, 22 strobe bits}
   localparam logic [21:0] S_MEMW  = 22'd1 << 21, S_ARW  = 22'd1 << 20, S_ARINC = 22'd1 << 19;
   localparam logic [21:0] S_PCW   = 22'd1 << 17, S_PCINC = 22'd1 << 16;
   localparam logic [21:0] S_DRW   = 22'd1 << 14, S_DRINC = 22'd1 << 13;
   localparam logic [21:0] S_ACW   = 22'd1 << 11, S_ACINC = 22'd1 << 10, S_ACCLR = 22'd1 << 9;
   localparam logic [21:0] S_IRW   = 22'd1 << 8;
   localparam logic [21:0] S_EW    = 22'd1 << 3, S_ECLR = 22'd1 << 2, S_ECMP = 22'd1 << 1;
   localparam logic [21:0] S_DONE  = 22'd1;

   function automatic logic [27:0] obs_word();
      return {ifc.BUS_SEL, ifc.ALU_SEL, ifc.MEM_write,
              ifc.AR_write, ifc.AR_increment, ifc.AR_clear,
              ifc.PC_write, ifc.PC_increment, ifc.PC_clear,
              ifc.DR_write, ifc.DR_increment, ifc.DR_clear,
              ifc.AC_write, ifc.AC_increment, ifc.AC_clear,
              ifc.IR_write, ifc.TR_write, ifc.TR_increment, ifc.TR_clear,
              ifc.OUTR_write, ifc.E_write, ifc.E_clear, ifc.E_complement,
              ifc.instr_done};
   endfunction

   function automatic logic [27:0] mk(input logic [2:0] bus, input logic [2:0] alu,
                                      input logic [21:0] s);
      return {bus, alu, s};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference model: one list of micro-operations per T-state, built from the
   // instruction table of the Mano machine.
   task automatic push_expected(input logic [15:0] ir, input logic [15:0] ac,
                                input logic [15:0] dr, input logic e);
      logic [2:0]  d;
      logic        ind;
      int          top;
      logic [2:0]  alu;
      logic [21:0] s;
      logic [27:0] rd;
      d   = ir[14:12];
      ind = ir[15];
      rd  = mk(3'd7, 3'd0, S_DRW);
      exp_q.push_back(mk(3'd2, 3'd0, S_ARW));
      exp_q.push_back(mk(3'd7, 3'd0, S_IRW | S_PCINC));
      exp_q.push_back(mk(3'd5, 3'd0, S_ARW));
      if (d == 3'd7) begin
         if (ind) exp_q.push_back(mk(3'd0, 3'd0, S_DONE));
         else begin
            top = -1;
            for (int b = 11; b >= 0; b--) if (ir[b]) begin top = b; break; end
            s = S_DONE; alu = 3'd0;
            case (top)
               11: s |= S_ACCLR;
               10: s |= S_ECLR;
               9:  begin alu = 3'd3; s |= S_ACW; end
               8:  s |= S_ECMP;
               7:  begin alu = 3'd4; s |= S_ACW | S_EW; end
               6:  begin alu = 3'd5; s |= S_ACW | S_EW; end
               5:  s |= S_ACINC;
               4:  if (ac[15] == 1'b0) s |= S_PCINC;
               3:  if (ac[15] == 1'b1) s |= S_PCINC;
               2:  if (ac == 16'h0)    s |= S_PCINC;
               1:  if (e == 1'b0)      s |= S_PCINC;
               default: ;
            endcase
            exp_q.push_back(mk(3'd0, alu, s));
         end
      end else begin
         exp_q.push_back(ind ? mk(3'd7, 3'd0, S_ARW) : 28'h0);
         case (d)
            3'd0: begin exp_q.push_back(rd); exp_q.push_back(mk(3'd0, 3'd0, S_ACW | S_DONE)); end
            3'd1: begin exp_q.push_back(rd); exp_q.push_back(mk(3'd0, 3'd1, S_ACW | S_EW | S_DONE)); end
            3'd2: begin exp_q.push_back(rd); exp_q.push_back(mk(3'd0, 3'd2, S_ACW | S_DONE)); end
            3'd3: exp_q.push_back(mk(3'd4, 3'd0, S_MEMW | S_DONE));
            3'd4: exp_q.push_back(mk(3'd1, 3'd0, S_PCW | S_DONE));
            3'd5: begin
               exp_q.push_back(mk(3'd2, 3'd0, S_MEMW | S_ARINC));
               exp_q.push_back(mk(3'd1, 3'd0, S_PCW | S_DONE));
            end
            default: begin
               exp_q.push_back(rd);
               exp_q.push_back(mk(3'd0, 3'd0, S_DRINC));
               exp_q.push_back(mk(3'd3, 3'd0, S_MEMW | S_DONE | ((dr == 16'h0) ? S_PCINC : 22'h0)));
            end
         endcase
      end
   endtask

   // Call with SC at T0 and clk high. Each T-state is compared at the falling edge.
   task automatic run_instr(input string tag, input logic [15:0] ir, input logic [15:0] ac,
                            input logic [15:0] dr, input logic e);
      int k;
      logic [27:0] ev;
      ifc.IR = ir; ifc.AC = ac; ifc.DR = dr; ifc.E = e;
      push_expected(ir, ac, dr, e);
      k = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         ev = exp_q.pop_front();
         check({tag, "_out"}, {4'h0, obs_word()}, {4'h0, ev});
         check({tag, "_sc"}, {28'h0, ifc.SC}, k);
         check({tag, "_halted"}, {31'h0, ifc.halted}, 32'h0);
         k++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      logic [15:0] rir, rac, rdr;
      logic [11:0] low;
      ifc.IR = 16'h1123; ifc.AC = 16'h0; ifc.DR = 16'h0; ifc.E = 1'b0;

      // Reset holds every output at 0.
      #2;
      check("rst_out", {4'h0, obs_word()}, 32'h0);
      check("rst_sc", {28'h0, ifc.SC}, 32'h0);
      check("rst_halted", {31'h0, ifc.halted}, 32'h0);
      release_reset();

      // Directed instructions.
      run_instr("add_dir", 16'h1123, 16'h1234, 16'h0001, 1'b0);
      run_instr("sta_ind", 16'hB050, 16'h5555, 16'h0000, 1'b1);
      run_instr("isz_wrap", 16'h6040, 16'h0000, 16'h0000, 1'b0);
      run_instr("isz_nowrap", 16'h6040, 16'h0000, 16'h0004, 1'b0);
      run_instr("spa_pos", 16'h7010, 16'h7FFF, 16'h0000, 1'b0);
      run_instr("spa_neg", 16'h7010, 16'h8000, 16'h0000, 1'b0);
      run_instr("cla_cle", 16'h7A00, 16'h1111, 16'h0000, 1'b1);
      run_instr("io_nop", 16'hF800, 16'h0000, 16'h0000, 1'b0);
      run_instr("bsa_ind", 16'hD100, 16'h0000, 16'h0000, 1'b0);
      run_instr("reg_nop", 16'h7000, 16'h0000, 16'h0000, 1'b0);

      // A reset in the middle of an instruction aborts it. Fetch restarts at T0.
      ifc.IR = 16'h2010;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_out", {4'h0, obs_word()}, 32'h0);
      check("abort_sc", {28'h0, ifc.SC}, 32'h0);
      release_reset();
      run_instr("after_abort", 16'hA077, 16'h0000, 16'h0000, 1'b0);

      // Randomised instruction stream, HLT excluded.
      for (int n = 0; n < 60; n++) begin
         rir = 16'($urandom_range(0, 65535));
         case ($urandom_range(0, 2))
            0: low = 12'h0;
            1: low = 12'd1 << $urandom_range(1, 11);
            default: low = 12'($urandom_range(0, 4095));
         endcase
         if (low == 12'h001) low = 12'h002;
         rir[11:0] = low;
         case ($urandom_range(0, 3))
            0: rac = 16'h0000;
            1: rac = 16'h8000 | 16'($urandom_range(0, 32767));
            default: rac = 16'($urandom_range(0, 65535));
         endcase
         rdr = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
         run_instr("rand", rir, rac, rdr, 1'($urandom_range(0, 1)));
      end

      // HLT: the machine then stays silent with SC frozen at 0.
      run_instr("hlt", 16'h7001, 16'h0000, 16'h0000, 1'b0);
      for (int n = 0; n < 10; n++) begin
         ifc.IR = 16'($urandom_range(0, 65535));
         @(negedge clk);
         check("halt_out", {4'h0, obs_word()}, 32'h0);
         check("halt_sc", {28'h0, ifc.SC}, 32'h0);
         check("halt_flag", {31'h0, ifc.halted}, 32'h1);
      end
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("halt_rst_flag", {31'h0, ifc.halted}, 32'h0);
      release_reset();
      run_instr("after_halt", 16'h4123, 16'h0000, 16'h0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mano_control_unit.md
Name: mano_control_unit

Overview:
- Hardwired control unit for the Mano basic computer; sits directly upstream of the datapath and drives every datapath control input.
- Contains the sequence counter SC, timing decode T0..T6, the indirect flag I and the halt flag S.
- Combinationally decodes SC, IR, AC, DR and E into bus select, ALU select and register/memory strobes.
- Executes memory-reference and register-reference instructions; I/O opcodes execute as NOPs.

Parameters:
- SC_W, 4, sequence counter width; only T0..T6 are used.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- IR  in  16  instruction register from datapath.
- AC  in  16  accumulator from datapath.
- DR  in  16  data register from datapath.
- E  in  1  carry/extend flag from datapath.
- BUS_SEL  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- ALU_SEL  out  3  ALU op: 000 AND, 001 ADD, 010 pass DR, 011 complement AC, 100 CIR, 101 CIL.
- MEM_write  out  1  memory write strobe.
- AR_write, AR_increment, AR_clear  out  1 each  AR strobes.
- PC_write, PC_increment, PC_clear  out  1 each  PC strobes.
- DR_write, DR_increment, DR_clear  out  1 each  DR strobes.
- AC_write, AC_increment, AC_clear  out  1 each  AC strobes.
- IR_write  out  1  IR load strobe.
- TR_write, TR_increment, TR_clear  out  1 each  TR strobes; held 0 in this revision.
- OUTR_write  out  1  held 0 in this revision.
- E_write, E_clear, E_complement  out  1 each  E strobes; E_write loads ALU carry-out.
- SC  out  SC_W  current sequence count.
- halted  out  1  S flag; high after HLT.
- instr_done  out  1  high during the last T-state of each instruction.

Behaviour:
- Reset (reset_n low, asynchronous):
  - SC=0, I=0, halted=0.
  - Every strobe, BUS_SEL, ALU_SEL and instr_done forced 0 while reset_n is low.
- Outputs: combinational from SC, I, IR, AC, DR, E and halted.
  - An output not named in the current T-state is 0.
  - ALU_SEL is 000 unless AC_write is asserted.
- SC increments each clock. Any T-state asserting instr_done clears SC to 0 at the next edge.
- I is loaded from IR[15] at the end of T2. D = IR[14:12].
- Fetch/decode (all instructions):
  - T0: BUS_SEL=2, AR_write.
  - T1: BUS_SEL=7, IR_write, PC_increment.
  - T2: BUS_SEL=5, AR_write.
- T3:
  - D!=7 and I=1: BUS_SEL=7, AR_write (indirect address).
  - D!=7 and I=0: no strobes.
  - D=7 and I=0: register-reference execute, instr_done.
  - D=7 and I=1: I/O NOP, instr_done.
- Memory-reference instructions by D:
  - AND (0): T4 BUS_SEL=7, DR_write. T5 ALU_SEL=000, AC_write, instr_done.
  - ADD (1): T4 DR<-M. T5 ALU_SEL=001, AC_write, E_write, instr_done.
  - LDA (2): T4 DR<-M. T5 ALU_SEL=010, AC_write, instr_done.
  - STA (3): T4 BUS_SEL=4, MEM_write, instr_done.
  - BUN (4): T4 BUS_SEL=1, PC_write, instr_done.
  - BSA (5): T4 BUS_SEL=2, MEM_write, AR_increment. T5 BUS_SEL=1, PC_write, instr_done.
  - ISZ (6): T4 DR<-M. T5 DR_increment. T6 BUS_SEL=3, MEM_write, PC_increment if DR==0, instr_done.
- Register-reference at T3: only the highest-numbered set bit of IR[11:0] executes; IR[11:0]==0 is a NOP.
  - Bit 11 CLA: AC_clear.
  - Bit 10 CLE: E_clear.
  - Bit 9 CMA: ALU_SEL=011, AC_write.
  - Bit 8 CME: E_complement.
  - Bit 7 CIR: ALU_SEL=100, AC_write, E_write.
  - Bit 6 CIL: ALU_SEL=101, AC_write, E_write.
  - Bit 5 INC: AC_increment.
  - Bit 4 SPA: PC_increment if AC[15]==0.
  - Bit 3 SNA: PC_increment if AC[15]==1.
  - Bit 2 SZA: PC_increment if AC==0.
  - Bit 1 SZE: PC_increment if E==0.
  - Bit 0 HLT: halted set at the next edge.
- Halted state:
  - SC frozen at 0; all strobes and instr_done held 0.
  - Exit only via reset.
- Reset mid-instruction aborts immediately; the next instruction starts with a fetch at T0.

Test Plan:
- Reset, release, IR don't-care -> T0: BUS_SEL=2, AR_write=1. T1: BUS_SEL=7, IR_write=1, PC_increment=1. T2: BUS_SEL=5, AR_write=1.
- IR=16'h1123 (ADD direct) -> T3 no strobes. T5: ALU_SEL=001, AC_write=1, E_write=1, instr_done=1. SC=0 next cycle.
- IR=16'hB050 (STA indirect) -> T3: BUS_SEL=7, AR_write=1. T4: BUS_SEL=4, MEM_write=1, instr_done=1.
- IR=16'h6040 (ISZ), DR=16'hFFFF at T4:
  - T5: DR_increment=1.
  - T6 with DR=0: MEM_write=1, PC_increment=1.
  - Repeat with DR=16'h0004 -> PC_increment=0 at T6.
- IR=16'h7010 (SPA): AC=16'h7FFF -> PC_increment=1 at T3; AC=16'h8000 -> PC_increment=0. IR=16'h7A00 -> only AC_clear asserted.
- IR=16'h7001 (HLT) -> halted=1 and SC stays 0 for 10 cycles with all strobes 0. Pulse reset_n low -> halted=0, fetch resumes at T0.
